// File: rtl/cfg_delay_pkg.sv
// cfg_delay_pkg
//   Shared types and constants for the runtime-configured delay line:
//   config FSM state encoding, register addresses and config bus width.
package cfg_delay_pkg;

  localparam int CFG_W = 8;

  localparam logic [1:0] ADDR_WIDTH = 2'd0;
  localparam logic [1:0] ADDR_DELAY = 2'd1;
  localparam logic [1:0] ADDR_COUNT = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/delay_stage_chain.sv
// delay_stage_chain
//   MAX_DELAY-deep shift register of {valid, data} with synchronous clear,
//   a runtime tap select and a popcount of valid bits in the active window.
// Ports
//   clk, rst       clock, async active-high reset
//   clr            synchronous clear of every stage (input dropped that edge)
//   in_valid/data  stage 0 capture; data is zeroed when valid is low
//   delay          active length, 1..MAX_DELAY; tap is stage delay-1
//   out_valid/data tapped stage
//   vld_cnt        set valid bits in stages 0..delay-1, saturated to 255
module delay_stage_chain #(
  parameter int DATA_W    = 8,
  parameter int MAX_DELAY = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [7:0]        delay,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [7:0]        vld_cnt
);

  logic [MAX_DELAY-1:0]             vld_pipe;
  logic [MAX_DELAY-1:0][DATA_W-1:0] dat_pipe;
  int                               cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else if (clr) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= in_valid;
      // Data rides with valid so an empty stage always reads as zero.
      dat_pipe[0] <= in_valid ? in_data : '0;
      for (int i = 1; i < MAX_DELAY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  // Compare-based tap/window select avoids a variable index whose width
  // depends on MAX_DELAY.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    cnt       = 0;
    for (int i = 0; i < MAX_DELAY; i++) begin
      if (i == int'(delay) - 1) begin
        out_valid = vld_pipe[i];
        out_data  = dat_pipe[i];
      end
      if (i < int'(delay) && vld_pipe[i]) cnt++;
    end
  end

  assign vld_cnt = (cnt > 255) ? 8'hFF : cnt[7:0];

endmodule

// File: rtl/cfg_delay_line.sv
// cfg_delay_line
//   Registered sampler with runtime width mask and cycle delay, configured
//   over a four-phase req/ack port (IDLE -> EXEC -> ACK).
// Ports
//   clk, rst               clock, async active-high reset
//   in_valid, in_data      input sample, no back-pressure
//   out_valid, out_data    sample delayed by 'delay' cycles, masked by 'width'
//   cfg_req/wr/addr/wdata  config request (latched on req in IDLE)
//   cfg_ack/rdata/err      config response, rdata/err valid while ack
//   busy                   accepted delay write executing; input dropped
module cfg_delay_line
  import cfg_delay_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_DELAY = 16,
  parameter int DEF_WIDTH = 8,
  parameter int DEF_DELAY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              cfg_req,
  input  logic              cfg_wr,
  input  logic [1:0]        cfg_addr,
  input  logic [CFG_W-1:0]  cfg_wdata,
  output logic              cfg_ack,
  output logic [CFG_W-1:0]  cfg_rdata,
  output logic              cfg_err,
  output logic              busy
);

  state_t            state, state_nxt;
  logic              lat_wr;
  logic [1:0]        lat_addr;
  logic [CFG_W-1:0]  lat_wdata;
  logic [7:0]        width_q, delay_q;
  logic [DATA_W-1:0] mask;
  logic              wd_ok_w, wd_ok_d;
  logic              exec_wr_width, exec_wr_delay;
  logic [CFG_W-1:0]  rd_val;
  logic              rd_err;
  logic [7:0]        vld_cnt;

  assign wd_ok_w = (lat_wdata != '0) && (int'(lat_wdata) <= DATA_W);
  assign wd_ok_d = (lat_wdata != '0) && (int'(lat_wdata) <= MAX_DELAY);

  assign exec_wr_width = (state == EXEC) && lat_wr && (lat_addr == ADDR_WIDTH) && wd_ok_w;
  assign exec_wr_delay = (state == EXEC) && lat_wr && (lat_addr == ADDR_DELAY) && wd_ok_d;

  assign busy    = exec_wr_delay;
  assign cfg_ack = (state == ACK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_req) state_nxt = EXEC;
      EXEC:    state_nxt = ACK;
      ACK:     if (!cfg_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Response for the latched access; writes return rdata=0.
  always_comb begin
    rd_val = '0;
    rd_err = 1'b0;
    case (lat_addr)
      ADDR_WIDTH: if (lat_wr) rd_err = !wd_ok_w; else rd_val = width_q;
      ADDR_DELAY: if (lat_wr) rd_err = !wd_ok_d; else rd_val = delay_q;
      ADDR_COUNT: if (lat_wr) rd_err = 1'b1;     else rd_val = vld_cnt;
      default:    rd_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      width_q   <= 8'(DEF_WIDTH);
      delay_q   <= 8'(DEF_DELAY);
      cfg_rdata <= '0;
      cfg_err   <= 1'b0;
    end else begin
      if (state == IDLE && cfg_req) begin
        lat_wr    <= cfg_wr;
        lat_addr  <= cfg_addr;
        lat_wdata <= cfg_wdata;
      end
      if (exec_wr_width) width_q <= lat_wdata;
      if (exec_wr_delay) delay_q <= lat_wdata;
      if (state == EXEC) begin
        cfg_rdata <= rd_val;
        cfg_err   <= rd_err;
      end else if (state == ACK && !cfg_req) begin
        cfg_rdata <= '0;
        cfg_err   <= 1'b0;
      end
    end
  end

  // Mask from the current width; a new width therefore affects captures
  // from the edge after EXEC, in-flight samples keep their old mask.
  always_comb begin
    mask = '0;
    for (int i = 0; i < DATA_W; i++) mask[i] = (i < int'(width_q));
  end

  delay_stage_chain #(
    .DATA_W    (DATA_W),
    .MAX_DELAY (MAX_DELAY)
  ) u_chain (
    .clk       (clk),
    .rst       (rst),
    .clr       (exec_wr_delay),
    .in_valid  (in_valid),
    .in_data   (in_data & mask),
    .delay     (delay_q),
    .out_valid (out_valid),
    .out_data  (out_data),
    .vld_cnt   (vld_cnt)
  );

endmodule
